mjpeg_slot_scheduler: RTL and testbench
=======================================

Name: mjpeg_slot_scheduler

Overview:
- Sequences the DDR3 JPEG read path.
- Owns a ring of DDR3 frame slots. It hands the JPEG writer a free slot address, then records each finished frame (slot plus byte length) as pending.
- Issues pending frames one at a time to the DDR3-to-UDP reader and frees each slot when the reader's busy falls.
- Sits between the JPEG encoder's DDR3 write side and the DDR3 read/UDP packetiser.

Parameters:
SLOT_NUM, 4, number of frame slots, power of two, 2..16
BASE_ADDR, 24'h000000, DDR3 address of slot 0
SLOT_STRIDE, 24'h010000, address distance between consecutive slots
SLOT_MAX_BYTES, 25'd262144, largest legal frame length in bytes
START_TIMEOUT, 16'd1024, cycles allowed from o_rd_en until i_rd_busy rises

Ports:
i_pclk84m  in  1  system clock; all logic on its rising edge
i_rst  in  1  asynchronous, active-high reset
o_wr_ready  out  1  a free slot is available to the writer
o_wr_addr  out  24  start address of the current write slot
i_wr_done  in  1  one-cycle pulse: writer finished the frame in the current slot
i_wr_len  in  25  frame byte length, valid with i_wr_done
o_rd_en  out  1  one-cycle start pulse to the reader
o_rd_addr  out  24  slot address of the issued frame
o_rd_len  out  25  byte length of the issued frame
i_rd_busy  in  1  reader busy
o_pending  out  5  number of slots holding frames not yet released
o_drop_cnt  out  16  frames rejected (no free slot or zero length), saturating
o_frame_cnt  out  16  frames completed by the reader, wrapping
o_err_len  out  1  sticky: a frame exceeded SLOT_MAX_BYTES
o_err_timeout  out  1  sticky: reader failed to start within START_TIMEOUT

Behaviour:
- Reset (asynchronous, any time, including mid-transfer) clears:
  - write and read slot pointers, o_pending, both counters and both error flags;
  - o_rd_en, o_rd_addr, o_rd_len to 0; state goes to IDLE.
- After reset, o_wr_ready=1 and o_wr_addr=BASE_ADDR.
- Slot address = BASE_ADDR + idx*SLOT_STRIDE, truncated to 24 bits (wraps modulo 2^24). Slot indices wrap SLOT_NUM-1 -> 0.
- o_wr_ready = (o_pending < SLOT_NUM), combinational. o_wr_addr always reflects the write-pointer slot.
- i_wr_done handling:
  - Accepted when o_wr_ready=1 and i_wr_len != 0: stores the length; write pointer and o_pending advance on the next edge.
  - If i_wr_len > SLOT_MAX_BYTES: store SLOT_MAX_BYTES instead and set o_err_len.
  - Ignored and o_drop_cnt increments when o_wr_ready=0 or i_wr_len=0. o_drop_cnt saturates at 16'hFFFF.
- Read FSM:
  - IDLE: if o_pending != issued count (an unissued frame exists), load o_rd_addr/o_rd_len from the read-pointer slot and go to ISSUE.
  - ISSUE: o_rd_en=1 for exactly this cycle; clear the timeout counter; go to WAIT_START.
  - WAIT_START: on i_rd_busy=1 go to WAIT_DONE. If the counter reaches START_TIMEOUT first, set o_err_timeout and go to RELEASE.
  - WAIT_DONE: on i_rd_busy 1->0 (registered edge detect) go to RELEASE. There is no timeout in this state.
  - RELEASE: advance the read pointer, decrement o_pending, increment o_frame_cnt (only when not a timeout), go to IDLE.
- o_rd_addr and o_rd_len hold stable from ISSUE until the next load.
- Minimum issue latency: i_wr_done at cycle N -> o_rd_en at N+2 when the FSM is idle.
- Back-to-back frames: RELEASE -> IDLE -> ISSUE, so a 2-cycle gap after the busy fall.
- Simultaneous accepted i_wr_done and RELEASE in the same cycle: o_pending stays unchanged, both pointers move.
- A slot being read is never offered to the writer. It counts in o_pending until RELEASE.
- i_rd_busy already high while in IDLE or ISSUE is treated as started only once the FSM is in WAIT_START.

Test Plan:
- Reset release, one frame (i_wr_done, len=1456) with the reader raising busy 3 cycles after o_rd_en and dropping it 100 cycles later:
  - o_rd_en 2 cycles after i_wr_done, o_rd_addr=0x000000, o_rd_len=1456;
  - after RELEASE o_pending=0, o_frame_cnt=1, o_wr_addr=0x010000.
- Five frames written with the reader stalled (busy held high):
  - fifth i_wr_done dropped, o_wr_ready=0, o_pending=4, o_drop_cnt=1;
  - after release, addresses cycle 0x00/0x01/0x02/0x03/0x00 (x0x10000).
- Zero-length i_wr_done and a len=300000 frame:
  - zero-length: o_drop_cnt+1 and o_pending unchanged;
  - oversize: o_rd_len=262144 and o_err_len=1.
- Reader never asserts busy:
  - o_err_timeout=1 at 1024 cycles after o_rd_en;
  - slot freed, o_frame_cnt unchanged, next frame issued.
- i_wr_done on the same cycle as RELEASE with o_pending=2: o_pending stays 2, both pointers advance.
- Assert i_rst during WAIT_DONE: all outputs return to reset values immediately; no o_rd_en after deassertion until a new i_wr_done.

Source files
------------

// File: rtl/mjpeg_slot_scheduler.sv
// Frame-slot ring between the JPEG DDR3 writer and the DDR3-to-UDP reader.
// Hands out free slots, queues finished frames and issues them one at a time.
module mjpeg_slot_scheduler #(
  parameter int          SLOT_NUM       = 4,
  parameter logic [23:0] BASE_ADDR      = 24'h000000,
  parameter logic [23:0] SLOT_STRIDE    = 24'h010000,
  parameter logic [24:0] SLOT_MAX_BYTES = 25'd262144,
  parameter logic [15:0] START_TIMEOUT  = 16'd1024
) (
  input  logic        i_pclk84m,
  input  logic        i_rst,
  output logic        o_wr_ready,
  output logic [23:0] o_wr_addr,
  input  logic        i_wr_done,
  input  logic [24:0] i_wr_len,
  output logic        o_rd_en,
  output logic [23:0] o_rd_addr,
  output logic [24:0] o_rd_len,
  input  logic        i_rd_busy,
  output logic [4:0]  o_pending,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_len,
  output logic        o_err_timeout
);

  localparam int IW = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0] r_wr_ptr;
  logic [IW-1:0] r_rd_ptr;
  logic [4:0]    r_pending;
  logic [24:0]   r_len [SLOT_NUM];
  logic [15:0]   r_to_cnt;
  logic [15:0]   r_drop_cnt;
  logic [15:0]   r_frame_cnt;
  logic          r_err_len;
  logic          r_err_to;
  logic          r_timed_out;
  logic          r_busy_q;
  logic [23:0]   r_rd_addr;
  logic [24:0]   r_rd_len;

  logic          w_wr_acc;
  logic          w_wr_drop;
  logic          w_len_ovf;
  logic [24:0]   w_wr_len;
  logic          w_rel;
  logic          w_load;
  logic          w_to_hit;
  logic          w_to_fire;
  logic          w_busy_fall;

  function automatic logic [23:0] slot_addr(
    input logic [IW-1:0] idx
  );
    logic [23:0] w_off;
    w_off = 24'(idx) * SLOT_STRIDE;
    return BASE_ADDR + w_off;
  endfunction

  assign o_wr_ready = (r_pending < 5'(SLOT_NUM));
  assign o_wr_addr  = slot_addr(r_wr_ptr);

  assign w_wr_acc  = i_wr_done & o_wr_ready
                   & (i_wr_len != 25'd0);
  assign w_wr_drop = i_wr_done & ~w_wr_acc;
  assign w_len_ovf = (i_wr_len > SLOT_MAX_BYTES);
  assign w_wr_len  = w_len_ovf ? SLOT_MAX_BYTES
                               : i_wr_len;

  // Terminal count lands the error flag exactly
  // START_TIMEOUT cycles after the o_rd_en cycle.
  assign w_to_hit    = (r_to_cnt == START_TIMEOUT - 16'd2);
  assign w_busy_fall = r_busy_q & ~i_rd_busy;
  assign w_rel       = (r_state == S_RELEASE);
  assign w_to_fire   = (r_state == S_WAIT_START)
                     & ~i_rd_busy & w_to_hit;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending != 5'd0) begin
          w_next = S_ISSUE;
          w_load = 1'b1;
        end
      end
      S_ISSUE: w_next = S_WAIT_START;
      S_WAIT_START: begin
        if (i_rd_busy) begin
          w_next = S_WAIT_DONE;
        end else if (w_to_hit) begin
          w_next = S_RELEASE;
        end
      end
      S_WAIT_DONE: begin
        if (w_busy_fall) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk84m) begin
    if (w_wr_acc) begin
      r_len[r_wr_ptr] <= w_wr_len;
    end
  end

  always_ff @(posedge i_pclk84m or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pending   <= 5'd0;
      r_to_cnt    <= 16'd0;
      r_drop_cnt  <= 16'd0;
      r_frame_cnt <= 16'd0;
      r_err_len   <= 1'b0;
      r_err_to    <= 1'b0;
      r_timed_out <= 1'b0;
      r_busy_q    <= 1'b0;
      r_rd_addr   <= 24'd0;
      r_rd_len    <= 25'd0;
    end else begin
      r_state  <= w_next;
      r_busy_q <= i_rd_busy;
      if (w_load) begin
        r_rd_addr <= slot_addr(r_rd_ptr);
        r_rd_len  <= r_len[r_rd_ptr];
      end
      if (r_state == S_ISSUE) begin
        r_to_cnt    <= 16'd0;
        r_timed_out <= 1'b0;
      end else if (r_state == S_WAIT_START) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_to_fire) begin
        r_err_to    <= 1'b1;
        r_timed_out <= 1'b1;
      end
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + IW'(1);
        if (w_len_ovf) begin
          r_err_len <= 1'b1;
        end
      end
      if (w_wr_drop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_rel) begin
        r_rd_ptr <= r_rd_ptr + IW'(1);
        if (!r_timed_out) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
      case ({w_wr_acc, w_rel})
        2'b10:   r_pending <= r_pending + 5'd1;
        2'b01:   r_pending <= r_pending - 5'd1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign o_rd_en       = (r_state == S_ISSUE);
  assign o_rd_addr     = r_rd_addr;
  assign o_rd_len      = r_rd_len;
  assign o_pending     = r_pending;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_err_len     = r_err_len;
  assign o_err_timeout = r_err_to;

endmodule

// File: tb/tb_mjpeg_slot_scheduler.sv
// Scoreboard bench for mjpeg_slot_scheduler: directed frames,
// expected reader issues queued and checked by a monitor.
module tb_mjpeg_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_done;
  logic [24:0] wr_len;
  logic        rd_busy;
  logic        wr_ready;
  logic [23:0] wr_addr;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [24:0] rd_len;
  logic [4:0]  pending;
  logic [15:0] drop_cnt;
  logic [15:0] frame_cnt;
  logic        err_len;
  logic        err_to;

  mjpeg_slot_scheduler dut (
    .i_pclk84m    (clk),
    .i_rst        (rst),
    .o_wr_ready   (wr_ready),
    .o_wr_addr    (wr_addr),
    .i_wr_done    (wr_done),
    .i_wr_len     (wr_len),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .o_rd_len     (rd_len),
    .i_rd_busy    (rd_busy),
    .o_pending    (pending),
    .o_drop_cnt   (drop_cnt),
    .o_frame_cnt  (frame_cnt),
    .o_err_len    (err_len),
    .o_err_timeout(err_to)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] addr;
    logic [24:0] len;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int rd_mode  = 0;
  int rd_seen  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reader model: 0 normal, 1 stalled busy, 2 never busy
  initial begin
    rd_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_mode == 1) begin
        rd_busy = 1'b1;
      end else if (rd_mode == 2) begin
        rd_busy = 1'b0;
      end else if (rd_en && !rst) begin
        repeat (3) @(negedge clk);
        rd_busy = 1'b1;
        repeat (100) @(negedge clk);
        rd_busy = 1'b0;
      end else begin
        rd_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rd_en) begin
      rd_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_issue: unexpected o_rd_en addr %0h len %0h",
                 rd_addr, rd_len);
      end else begin
        e = sb.pop_front();
        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
        chk("rd_len", 32'(rd_len), 32'(e.len));
        if (e.at >= 0) chk("rd_latency", cyc, e.at);
      end
    end
  end

  task automatic wr_frame(input logic [24:0] len,
                          input bit          push,
                          input logic [23:0] eaddr,
                          input logic [24:0] elen,
                          input bit          lat);
    exp_t e;
    @(posedge clk);
    #1;
    wr_done = 1'b1;
    wr_len  = len;
    if (push) begin
      e.addr = eaddr;
      e.len  = elen;
      e.at   = lat ? cyc + 2 : -1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    wr_done = 1'b0;
    wr_len  = 25'd0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (int'(frame_cnt) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_cnt_wait", 32'(frame_cnt), target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int el;
    int seen0;
    bit got;
    wr_done = 1'b0;
    wr_len  = 25'd0;
    rst     = 1'b1;
    #1;
    chk("rst_async_rd_en", 32'(rd_en), 0);
    do_reset();
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_frames", 32'(frame_cnt), 0);
    chk("rst_errs", {30'd0, err_len, err_to}, 0);
    chk("rst_rd", 32'(rd_addr) | 32'(rd_len), 0);

    // One frame through a normal reader
    rd_mode = 0;
    wr_frame(25'd1456, 1, 24'h000000, 25'd1456, 1);
    wait_frames(1, 300);
    @(negedge clk);
    chk("t1_pending", 32'(pending), 0);
    chk("t1_wr_addr", 32'(wr_addr), 32'h010000);

    // Ring full with reader stalled
    rd_mode = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_frame(25'(11 + i), 1, 24'(i * 32'h10000),
               25'(11 + i), 0);
    end
    wr_frame(25'd15, 0, 24'd0, 25'd0, 0);
    @(negedge clk);
    chk("t2_wr_ready", 32'(wr_ready), 0);
    chk("t2_pending", 32'(pending), 4);
    chk("t2_drop", 32'(drop_cnt), 1);
    rd_mode = 0;
    wait_frames(4, 700);
    wr_frame(25'd16, 1, 24'h000000, 25'd16, 0);
    wait_frames(5, 300);

    // Zero length and oversize frames
    wr_frame(25'd0, 0, 24'd0, 25'd0, 0);
    @(negedge clk);
    chk("t3_zero_drop", 32'(drop_cnt), 2);
    chk("t3_zero_pend", 32'(pending), 0);
    chk("t3_err_len_pre", 32'(err_len), 0);
    wr_frame(25'd300000, 1, 24'h010000, 25'd262144, 0);
    @(negedge clk);
    chk("t3_err_len", 32'(err_len), 1);
    wait_frames(6, 300);

    // Reader never starts
    chk("t4_err_to_pre", 32'(err_to), 0);
    rd_mode = 2;
    wr_frame(25'd50, 1, 24'h020000, 25'd50, 0);
    got = 0;
    t0  = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rd_en) begin
        got = 1;
        t0  = cyc;
      end
    end
    chk("t4_rd_en_seen", 32'(got), 1);
    el = -1;
    for (int i = 0; i < 1100 && el < 0; i++) begin
      @(negedge clk);
      if (err_to) el = cyc - t0;
    end
    chk("t4_timeout_cycles", el, 1024);
    repeat (3) @(negedge clk);
    chk("t4_pending", 32'(pending), 0);
    chk("t4_frames", 32'(frame_cnt), 6);
    rd_mode = 0;
    wr_frame(25'd60, 1, 24'h030000, 25'd60, 0);
    wait_frames(7, 300);

    // Write accepted in the RELEASE cycle
    rd_mode = 1;
    repeat (2) @(negedge clk);
    wr_frame(25'd68, 1, 24'h000000, 25'd68, 0);
    wr_frame(25'd69, 1, 24'h010000, 25'd69, 0);
    repeat (4) @(negedge clk);
    chk("t5_pending_pre", 32'(pending), 2);
    @(posedge clk);
    #1;
    rd_mode = 2;
    sb.push_back('{24'h020000, 25'd70, -1});
    @(posedge clk);
    #1;
    wr_done = 1'b1;
    wr_len  = 25'd70;
    @(negedge clk);
    chk("t5_pending_rel", 32'(pending), 2);
    @(posedge clk);
    #1;
    wr_done = 1'b0;
    wr_len  = 25'd0;
    @(negedge clk);
    rd_mode = 0;
    chk("t5_pending_post", 32'(pending), 2);
    chk("t5_wr_addr", 32'(wr_addr), 32'h030000);
    chk("t5_frames", 32'(frame_cnt), 8);
    wait_frames(10, 500);

    // Reset in WAIT_DONE
    rd_mode = 1;
    wr_frame(25'd80, 1, 24'h030000, 25'd80, 0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pending", 32'(pending), 0);
    chk("t6_frames", 32'(frame_cnt), 0);
    chk("t6_drop", 32'(drop_cnt), 0);
    chk("t6_errs", {30'd0, err_len, err_to}, 0);
    chk("t6_rd", 32'(rd_addr) | 32'(rd_len), 0);
    chk("t6_wr", {7'd0, wr_ready, wr_addr}, 32'h1000000);
    sb.delete();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rd_mode = 0;
    seen0   = rd_seen;
    repeat (40) @(negedge clk);
    chk("t6_no_rd_en", rd_seen, seen0);
    wr_frame(25'd90, 1, 24'h000000, 25'd90, 1);
    wait_frames(1, 300);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
